// File: rtl/waveform_readout_pkg.sv
// waveform_readout_pkg
// Shared types and constants for the waveform readout controller.
//   state_t           readout FSM state encoding
//   DEFAULT_HDR_BYTE  frame start byte
//   FRAME_BYTES_BASE  bytes per frame without timestamp (32 samples)
//   FRAME_BYTES_TS    bytes per frame with the 4-byte timestamp (32 samples)
package waveform_readout_pkg;

  typedef enum logic [3:0] {
    ST_ARMED,
    ST_CAPTURE,
    ST_SEND_HDR,
    ST_SEND_TS,
    ST_SEND_HI,
    ST_SEND_LO,
    ST_SEND_PH_HI,
    ST_SEND_PH_LO,
    ST_SEND_CKS,
    ST_HOLDOFF
  } state_t;

  localparam logic [7:0] DEFAULT_HDR_BYTE = 8'hA5;

  // header + 32 x {hi,lo} + ph hi + ph lo + checksum
  localparam int FRAME_BYTES_BASE = 68;
  localparam int FRAME_BYTES_TS   = 72;

endpackage

// File: rtl/waveform_readout_ctrl_tx_byte_reg.sv
// tx_byte_reg
// Single-entry valid/ready output register feeding the UART transmitter.
// A byte loaded here is held stable with tx_valid high until the UART
// accepts it. A new byte may be loaded in the same cycle the current one is
// accepted, giving one byte per cycle when tx_ready stays high. The caller
// only asserts load when the slot is empty or being accepted.
//   clk, rst_n   clock, asynchronous active-low reset
//   load         capture byte_in this cycle
//   byte_in      next byte to present
//   tx_ready     UART accepts the presented byte
//   tx_data      presented byte (registered)
//   tx_valid     tx_data is valid (registered)
//   accept       tx_valid & tx_ready: byte transfers this cycle
module tx_byte_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] byte_in,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       accept
);

  assign accept = tx_valid & tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else if (load) begin
      tx_data  <= byte_in;
      tx_valid <= 1'b1;
    end else if (accept) begin
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/waveform_readout_ctrl.sv
// waveform_readout_ctrl
// Arms the waveform capture block, waits for the capture window to close,
// then reads the 32-sample buffer out to the UART as a fixed byte frame:
//   HDR_BYTE, [ts3 ts2 ts1 ts0], NSAMP x {hi, lo}, ph hi, ph lo, checksum
// The checksum is the XOR of every byte after the header. After the last
// byte is accepted the controller idles HOLDOFF cycles before re-arming, and
// stays parked until enable is high.
//
// Optional build macro WAVEFORM_READOUT_TIMESTAMP_EN adds a free-running
// 32-bit cycle counter, latched on trigger_out and sent MSB first after the
// header (72-byte frame instead of 68).
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   enable            arms the controller when high
//   trigger_raw_in    raw discriminator trigger
//   trigger_out       gated trigger to capture block (combinational)
//   long_trigger_in   capture window active flag
//   pulse_height_in   pulse height, latched at the end of the window
//   sample_idx        capture buffer read index
//   sample_in         waveform[sample_idx], combinational read
//   tx_data/tx_valid  byte stream to UART TX, tx_ready is its acceptance
//   busy              high in every state except ARMED
//   dropped_count     rejected trigger rising edges, saturating
//
// state       | meaning
// ARMED       | waiting for a gated trigger
// CAPTURE     | waiting for the capture window (long_trigger_in) to fall
// SEND_HDR    | loading header byte
// SEND_TS     | loading the 4 timestamp bytes (timestamp build only)
// SEND_HI     | loading sample hi byte, latching the sample
// SEND_LO     | loading sample lo byte, advancing sample_idx
// SEND_PH_HI  | loading pulse height hi byte
// SEND_PH_LO  | loading pulse height lo byte
// SEND_CKS    | loading checksum byte
// HOLDOFF     | last byte drains, then HOLDOFF idle cycles before re-arm
module waveform_readout_ctrl
  import waveform_readout_pkg::*;
#(
  parameter int         NSAMP    = 32,
  parameter int         SAMP_W   = 14,
  parameter int         HOLDOFF  = 64,
  parameter logic [7:0] HDR_BYTE = DEFAULT_HDR_BYTE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     trigger_raw_in,
  output logic                     trigger_out,
  input  logic                     long_trigger_in,
  input  logic [SAMP_W-1:0]        pulse_height_in,
  output logic [$clog2(NSAMP)-1:0] sample_idx,
  input  logic [SAMP_W-1:0]        sample_in,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     busy,
  output logic [15:0]              dropped_count
);

  localparam int                IDX_W    = $clog2(NSAMP);
  localparam int                HO_W     = $clog2(HOLDOFF + 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NSAMP - 1);
  localparam logic [HO_W-1:0]   HO_LOAD  = HO_W'(HOLDOFF);
  localparam logic [HO_W-1:0]   HO_TC    = HO_W'(1);

  state_t              state;
  state_t              state_nxt;
  logic                trig_q;
  logic                long_q;
  logic                trig_rise;
  logic                window_fall;
  logic                load;
  logic [7:0]          byte_nxt;
  logic                accept;
  logic                slot_free;
  logic [7:0]          samp_lo;
  logic [SAMP_W-1:0]   ph_lat;
  logic [15:0]         samp_ext;
  logic [15:0]         ph_ext;
  logic [7:0]          cks;
  logic [HO_W-1:0]     ho_cnt;

`ifdef WAVEFORM_READOUT_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] ts_sh;
  logic [1:0]  ts_sel;
`endif

  assign trigger_out = trigger_raw_in & enable & (state == ST_ARMED);
  assign busy        = (state != ST_ARMED);
  assign trig_rise   = trigger_raw_in & ~trig_q;
  assign window_fall = long_q & ~long_trigger_in;
  // The output slot can take a byte when empty or when its byte leaves now.
  assign slot_free   = ~tx_valid | accept;
  assign samp_ext    = 16'(sample_in);
  assign ph_ext      = 16'(ph_lat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ARMED;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    byte_nxt  = 8'h00;
    case (state)
      ST_ARMED: begin
        if (trigger_out) state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // A window that is already low on entry needs a rise before the fall.
        if (window_fall) state_nxt = ST_SEND_HDR;
      end
      ST_SEND_HDR: begin
        if (slot_free) begin
          load     = 1'b1;
          byte_nxt = HDR_BYTE;
`ifdef WAVEFORM_READOUT_TIMESTAMP_EN
          state_nxt = ST_SEND_TS;
`else
          state_nxt = ST_SEND_HI;
`endif
        end
      end
      ST_SEND_TS: begin
`ifdef WAVEFORM_READOUT_TIMESTAMP_EN
        if (slot_free) begin
          load     = 1'b1;
          byte_nxt = ts_sh[31:24];
          if (ts_sel == 2'd3) state_nxt = ST_SEND_HI;
        end
`else
        state_nxt = ST_SEND_HI;
`endif
      end
      ST_SEND_HI: begin
        if (slot_free) begin
          load      = 1'b1;
          byte_nxt  = 8'(samp_ext >> 8);
          state_nxt = ST_SEND_LO;
        end
      end
      ST_SEND_LO: begin
        if (slot_free) begin
          load      = 1'b1;
          byte_nxt  = samp_lo;
          state_nxt = (sample_idx == IDX_LAST) ? ST_SEND_PH_HI : ST_SEND_HI;
        end
      end
      ST_SEND_PH_HI: begin
        if (slot_free) begin
          load      = 1'b1;
          byte_nxt  = ph_ext[15:8];
          state_nxt = ST_SEND_PH_LO;
        end
      end
      ST_SEND_PH_LO: begin
        if (slot_free) begin
          load      = 1'b1;
          byte_nxt  = ph_ext[7:0];
          state_nxt = ST_SEND_CKS;
        end
      end
      ST_SEND_CKS: begin
        if (slot_free) begin
          load      = 1'b1;
          byte_nxt  = cks;
          state_nxt = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (!tx_valid && (ho_cnt == HO_TC) && enable) state_nxt = ST_ARMED;
      end
      default: begin
        state_nxt = ST_ARMED;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q        <= 1'b0;
      long_q        <= 1'b0;
      dropped_count <= 16'h0000;
      ph_lat        <= '0;
      samp_lo       <= 8'h00;
      cks           <= 8'h00;
      sample_idx    <= '0;
      ho_cnt        <= '0;
    end else begin
      trig_q <= trigger_raw_in;
      long_q <= long_trigger_in;

      if (trig_rise && !(enable && (state == ST_ARMED)) &&
          (dropped_count != 16'hFFFF)) begin
        dropped_count <= dropped_count + 16'd1;
      end

      if ((state == ST_CAPTURE) && window_fall) begin
        ph_lat <= pulse_height_in;
        cks    <= 8'h00;
      end else if (load && (state != ST_SEND_HDR) && (state != ST_SEND_CKS)) begin
        cks <= cks ^ byte_nxt;
      end

      // Both bytes of a sample come from the value seen when hi is loaded.
      if (load && (state == ST_SEND_HI)) samp_lo <= 8'(sample_in);

      if (load && (state == ST_SEND_LO)) begin
        sample_idx <= sample_idx + IDX_W'(1);
      end else if ((state == ST_HOLDOFF) && (state_nxt == ST_ARMED)) begin
        sample_idx <= '0;
      end

      // Holdoff count starts only once the checksum byte has left.
      if (load && (state == ST_SEND_CKS)) begin
        ho_cnt <= HO_LOAD;
      end else if ((state == ST_HOLDOFF) && !tx_valid && (ho_cnt != HO_TC)) begin
        ho_cnt <= ho_cnt - HO_W'(1);
      end
    end
  end

`ifdef WAVEFORM_READOUT_TIMESTAMP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt <= 32'h0;
      ts_sh  <= 32'h0;
      ts_sel <= 2'd0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (trigger_out) begin
        ts_sh <= ts_cnt;
      end else if (load && (state == ST_SEND_TS)) begin
        ts_sh <= {ts_sh[23:0], 8'h00};
      end
      if (load && (state == ST_SEND_TS)) ts_sel <= ts_sel + 2'd1;
    end
  end
`endif

  tx_byte_reg u_tx_byte_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .byte_in  (byte_nxt),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .accept   (accept)
  );

endmodule

// File: tb/tb_waveform_readout_ctrl.sv
// tb_waveform_readout_ctrl
// Directed bench for waveform_readout_ctrl: builds the expected byte frame
// from its own copy of the capture buffer and compares the UART stream.
// Honours WAVEFORM_READOUT_TIMESTAMP_EN for frame layout.
module tb_waveform_readout_ctrl;
  import waveform_readout_pkg::*;

  localparam int NSAMP   = 32;
  localparam int SAMP_W  = 14;
  localparam int HOLDOFF = 64;
`ifdef WAVEFORM_READOUT_TIMESTAMP_EN
  localparam int TS_BYTES = 4;
  localparam int FLEN     = FRAME_BYTES_TS;
`else
  localparam int TS_BYTES = 0;
  localparam int FLEN     = FRAME_BYTES_BASE;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic              trigger_raw_in;
  logic              trigger_out;
  logic              long_trigger_in;
  logic [SAMP_W-1:0] pulse_height_in;
  logic [4:0]        sample_idx;
  logic [SAMP_W-1:0] sample_in;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic [15:0]       dropped_count;

  logic [SAMP_W-1:0] wave [NSAMP];
  logic [7:0]        exp_q[$];
  logic [7:0]        got_q[$];
  logic [31:0]       tb_cyc;
  int                checks = 0;
  int                errors = 0;
  int                hs_viol;
  int                nbad;
  int                bad_i;
  int                nidle;
  logic              tout;
  logic [31:0]       ts;

  always #5 clk = ~clk;

  assign sample_in = wave[sample_idx];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cyc <= 32'd0;
    else        tb_cyc <= tb_cyc + 32'd1;
  end

  waveform_readout_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .trigger_raw_in  (trigger_raw_in),
    .trigger_out     (trigger_out),
    .long_trigger_in (long_trigger_in),
    .pulse_height_in (pulse_height_in),
    .sample_idx      (sample_idx),
    .sample_in       (sample_in),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .busy            (busy),
    .dropped_count   (dropped_count)
  );

  function automatic void build_frame(input logic [15:0] ph, input logic [31:0] tsv);
    logic [7:0]  c;
    logic [15:0] w;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    c = 8'h00;
    if (TS_BYTES == 4) begin
      for (int k = 0; k < 4; k++) begin
        exp_q.push_back(tsv[31-8*k -: 8]);
        c ^= tsv[31-8*k -: 8];
      end
    end
    for (int i = 0; i < NSAMP; i++) begin
      w = 16'(wave[i]);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
      c ^= w[15:8] ^ w[7:0];
    end
    exp_q.push_back(ph[15:8]);
    exp_q.push_back(ph[7:0]);
    c ^= ph[15:8] ^ ph[7:0];
    exp_q.push_back(c);
  endfunction

  function automatic void frame_diff();
    nbad  = 0;
    bad_i = -1;
    if (got_q.size() != exp_q.size()) begin
      nbad = 1;
    end else begin
      foreach (exp_q[i]) begin
        if (got_q[i] !== exp_q[i]) begin
          if (bad_i < 0) bad_i = i;
          nbad++;
        end
      end
    end
  endfunction

  task automatic start_event(output logic t_out, output logic [31:0] t_stamp);
    @(posedge clk); #1;
    trigger_raw_in  = 1'b1;
    long_trigger_in = 1'b1;
    @(negedge clk);
    t_out   = trigger_out;
    t_stamp = tb_cyc;
    @(posedge clk); #1;
    trigger_raw_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    long_trigger_in = 1'b0;
  endtask

  // Collects up to nmax accepted bytes, driving tx_ready with pct% duty;
  // counts stalls where the presented byte changed or tx_valid dropped.
  task automatic collect(input int pct, input int nmax, input int budget);
    logic       prev_stall;
    logic [7:0] prev_data;
    got_q.delete();
    hs_viol    = 0;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    for (int c = 0; c < budget && got_q.size() < nmax; c++) begin
      @(posedge clk); #1;
      tx_ready = ($urandom_range(0, 99) < pct);
      @(negedge clk);
      if (prev_stall && (!tx_valid || tx_data !== prev_data)) hs_viol++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
    end
  endtask

  task automatic wait_idle(input int budget, output int n);
    n = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; trigger_raw_in = 1'b0; long_trigger_in = 1'b0;
    pulse_height_in = '0; tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (sample_idx !== 5'd0) begin errors++; $display("FAIL reset_sample_idx: got %0d want 0", sample_idx); end
    checks++; if (dropped_count !== 16'd0) begin errors++; $display("FAIL reset_dropped: got %0d want 0", dropped_count); end
    checks++; if (trigger_out !== 1'b0) begin errors++; $display("FAIL reset_trigger_out: got %b want 0", trigger_out); end
  endtask

  task automatic test_frame_basic();
    for (int i = 0; i < NSAMP; i++) wave[i] = SAMP_W'(i * 3);
    pulse_height_in = 14'h0123;
    start_event(tout, ts);
    build_frame(16'h0123, ts);
    checks++; if (tout !== 1'b1) begin errors++; $display("FAIL basic_trigger_out: got %b want 1", tout); end
    collect(100, FLEN, 400);
    frame_diff();
    checks++; if (nbad != 0) begin errors++; $display("FAIL basic_frame: got %0d bytes, %0d bad, first bad %0d; want %0d bytes all matching", got_q.size(), nbad, bad_i, exp_q.size()); end
    checks++; if (hs_viol != 0) begin errors++; $display("FAIL basic_handshake: got %0d stall violations want 0", hs_viol); end
    checks++; if (got_q[0] !== 8'hA5) begin errors++; $display("FAIL basic_header: got %h want a5", got_q[0]); end
    checks++; if (got_q[64+TS_BYTES] !== 8'h5D) begin errors++; $display("FAIL basic_last_sample_lo: got %h want 5d", got_q[64+TS_BYTES]); end
    checks++; if (got_q[FLEN-3] !== 8'h01 || got_q[FLEN-2] !== 8'h23) begin errors++; $display("FAIL basic_ph: got %h %h want 01 23", got_q[FLEN-3], got_q[FLEN-2]); end
    wait_idle(300, nidle);
    checks++; if (nidle != HOLDOFF) begin errors++; $display("FAIL basic_holdoff: got %0d busy cycles want %0d", nidle, HOLDOFF); end
    checks++; if (sample_idx !== 5'd0) begin errors++; $display("FAIL basic_idx_rearm: got %0d want 0", sample_idx); end
  endtask

  task automatic test_backpressure();
    pulse_height_in = 14'h0123;
    start_event(tout, ts);
    build_frame(16'h0123, ts);
    collect(30, FLEN, 3000);
    frame_diff();
    checks++; if (nbad != 0) begin errors++; $display("FAIL bp_frame: got %0d bytes, %0d bad, first bad %0d; want %0d bytes all matching", got_q.size(), nbad, bad_i, exp_q.size()); end
    checks++; if (hs_viol != 0) begin errors++; $display("FAIL bp_handshake: got %0d stall violations want 0", hs_viol); end
    wait_idle(300, nidle);
    checks++; if (nidle != HOLDOFF) begin errors++; $display("FAIL bp_holdoff: got %0d busy cycles want %0d", nidle, HOLDOFF); end
  endtask

  task automatic test_extremes_glitch();
    for (int i = 0; i < NSAMP; i++) wave[i] = 14'h3FFF;
    pulse_height_in = 14'h0000;
    @(posedge clk); #1;
    trigger_raw_in = 1'b1;
    @(negedge clk);
    ts = tb_cyc;
    @(posedge clk); #1;
    trigger_raw_in = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy: got %b want 1", busy); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL glitch_no_send: got tx_valid %b want 0", tx_valid); end
    @(posedge clk); #1 long_trigger_in = 1'b1;
    repeat (2) @(posedge clk);
    #1 long_trigger_in = 1'b0;
    build_frame(16'h0000, ts);
    collect(100, FLEN, 400);
    frame_diff();
    checks++; if (nbad != 0) begin errors++; $display("FAIL ext_frame: got %0d bytes, %0d bad, first bad %0d; want %0d bytes all matching", got_q.size(), nbad, bad_i, exp_q.size()); end
    checks++; if (got_q[1+TS_BYTES] !== 8'h3F || got_q[2+TS_BYTES] !== 8'hFF) begin errors++; $display("FAIL ext_sample_bytes: got %h %h want 3f ff", got_q[1+TS_BYTES], got_q[2+TS_BYTES]); end
    checks++; if (got_q[FLEN-3] !== 8'h00 || got_q[FLEN-2] !== 8'h00) begin errors++; $display("FAIL ext_ph: got %h %h want 00 00", got_q[FLEN-3], got_q[FLEN-2]); end
    wait_idle(300, nidle);
    checks++; if (nidle != HOLDOFF) begin errors++; $display("FAIL ext_holdoff: got %0d busy cycles want %0d", nidle, HOLDOFF); end
  endtask

  task automatic test_dropped();
    for (int i = 0; i < NSAMP; i++) wave[i] = SAMP_W'(i * 3);
    pulse_height_in = 14'h0123;
    tx_ready = 1'b0;
    start_event(tout, ts);
    build_frame(16'h0123, ts);
    for (int p = 0; p < 5; p++) begin
      @(posedge clk); #1 trigger_raw_in = 1'b1;
      @(negedge clk);
      checks++; if (trigger_out !== 1'b0) begin errors++; $display("FAIL drop_busy_trigger_out%0d: got %b want 0", p, trigger_out); end
      @(posedge clk); #1 trigger_raw_in = 1'b0;
    end
    collect(100, FLEN, 400);
    frame_diff();
    checks++; if (nbad != 0) begin errors++; $display("FAIL drop_frame: got %0d bytes, %0d bad, first bad %0d; want %0d bytes all matching", got_q.size(), nbad, bad_i, exp_q.size()); end
    wait_idle(300, nidle);
    @(posedge clk); #1 enable = 1'b0;
    for (int p = 0; p < 2; p++) begin
      @(posedge clk); #1 trigger_raw_in = 1'b1;
      @(negedge clk);
      checks++; if (trigger_out !== 1'b0) begin errors++; $display("FAIL drop_disabled_trigger_out%0d: got %b want 0", p, trigger_out); end
      @(posedge clk); #1 trigger_raw_in = 1'b0;
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_disabled_busy: got %b want 0", busy); end
    checks++; if (dropped_count !== 16'd7) begin errors++; $display("FAIL drop_count: got %0d want 7", dropped_count); end
    @(posedge clk); #1 enable = 1'b1;
  endtask

  task automatic test_enable_hold();
    start_event(tout, ts);
    enable = 1'b0;
    build_frame(16'h0123, ts);
    collect(100, FLEN, 400);
    frame_diff();
    checks++; if (nbad != 0) begin errors++; $display("FAIL hold_frame: got %0d bytes, %0d bad, first bad %0d; want %0d bytes all matching", got_q.size(), nbad, bad_i, exp_q.size()); end
    repeat (100) @(negedge clk);
    checks++; if (busy !== 1'b1 || tx_valid !== 1'b0) begin errors++; $display("FAIL hold_parked: got busy %b tx_valid %b want 1 0", busy, tx_valid); end
    // Re-enable and trigger in the very cycle the controller re-arms.
    @(posedge clk); #1;
    enable = 1'b1;
    trigger_raw_in = 1'b1;
    @(negedge clk);
    checks++; if (trigger_out !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL hold_rearm_cycle: got trigger_out %b busy %b want 0 1", trigger_out, busy); end
    @(posedge clk); #1 trigger_raw_in = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_rearmed: got busy %b want 0", busy); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_trigger_ignored: got busy %b want 0", busy); end
    checks++; if (dropped_count !== 16'd8) begin errors++; $display("FAIL hold_dropped: got %0d want 8", dropped_count); end
  endtask

  task automatic test_reset_midframe();
    start_event(tout, ts);
    collect(100, 20, 200);
    checks++; if (got_q.size() != 20) begin errors++; $display("FAIL rst_partial_len: got %0d want 20", got_q.size()); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs: got tx_valid %b busy %b want 0 0", tx_valid, busy); end
    checks++; if (dropped_count !== 16'd0 || sample_idx !== 5'd0 || tx_data !== 8'h00) begin errors++; $display("FAIL rst_mid_regs: got dropped %0d idx %0d data %h want 0 0 00", dropped_count, sample_idx, tx_data); end
    @(posedge clk); #1 rst_n = 1'b1;
    start_event(tout, ts);
    build_frame(16'h0123, ts);
    collect(100, FLEN, 400);
    frame_diff();
    checks++; if (nbad != 0) begin errors++; $display("FAIL rst_new_frame: got %0d bytes, %0d bad, first bad %0d; want %0d bytes all matching", got_q.size(), nbad, bad_i, exp_q.size()); end
    wait_idle(300, nidle);
    checks++; if (nidle != HOLDOFF) begin errors++; $display("FAIL rst_holdoff: got %0d busy cycles want %0d", nidle, HOLDOFF); end
  endtask

`ifdef WAVEFORM_READOUT_TIMESTAMP_EN
  task automatic test_timestamp();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (999) @(posedge clk);
    start_event(tout, ts);
    build_frame(16'h0123, 32'd1000);
    collect(100, FLEN, 400);
    frame_diff();
    checks++; if (nbad != 0) begin errors++; $display("FAIL ts_frame: got %0d bytes, %0d bad, first bad %0d; want %0d bytes all matching", got_q.size(), nbad, bad_i, exp_q.size()); end
    checks++; if (got_q[1] !== 8'h00 || got_q[2] !== 8'h00 || got_q[3] !== 8'h03 || got_q[4] !== 8'hE8) begin errors++; $display("FAIL ts_bytes: got %h %h %h %h want 00 00 03 e8", got_q[1], got_q[2], got_q[3], got_q[4]); end
    checks++; if (got_q.size() != 72) begin errors++; $display("FAIL ts_len: got %0d want 72", got_q.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_frame_basic();
    test_backpressure();
    test_extremes_glitch();
    test_dropped();
    test_enable_hold();
    test_reset_midframe();
`ifdef WAVEFORM_READOUT_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/waveform_readout_ctrl.md
Name: waveform_readout_ctrl

Overview:
- Sequences the 32-sample waveform capture block and ships each captured event to the UART transmitter as a fixed byte frame.
- Gates the raw trigger so a waveform is never overwritten while it is being read out.
- Reads the capture buffer one sample per byte pair through an index port, then applies a programmable holdoff before re-arming.
- Sits between the discriminator/trigger logic, the waveform capture block and the UART TX.

Parameters:
- NSAMP, 32, samples per waveform (power of two)
- SAMP_W, 14, ADC sample and pulse-height width (must be ≤16)
- HOLDOFF, 64, idle cycles after frame end before re-arming (≥1)
- HDR_BYTE, 8'hA5, frame start byte

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  arms the controller when high
- trigger_raw_in  in  1  raw trigger from discriminator
- trigger_out  out  1  gated trigger to capture block
- long_trigger_in  in  1  capture-window-active flag from capture block
- pulse_height_in  in  SAMP_W  pulse height from capture block
- sample_idx  out  $clog2(NSAMP)  buffer read index
- sample_in  in  SAMP_W  waveform[sample_idx], combinational read
- tx_data  out  8  byte to UART TX
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART TX accepts byte
- busy  out  1  high in any state except ARMED
- dropped_count  out  16  triggers rejected while not armed, saturating

Behaviour:
- Reset values: state=ARMED, trigger_out=0, sample_idx=0, tx_data=0, tx_valid=0, busy=0, dropped_count=0, checksum=0, latched pulse height=0.
- trigger_out = trigger_raw_in & enable & (state==ARMED); combinational, zero latency.
- States:
  - ARMED → CAPTURE on trigger_out=1.
  - CAPTURE: wait for long_trigger_in falling edge, detected with a registered copy. On that edge latch pulse_height_in and go to SEND_HDR.
  - SEND_HDR → SEND_HI → SEND_LO. SEND_LO increments sample_idx; after idx NSAMP-1 it goes to SEND_PH_HI, otherwise back to SEND_HI.
  - SEND_PH_HI → SEND_PH_LO → SEND_CKS → HOLDOFF.
  - HOLDOFF counts HOLDOFF cycles, then returns to ARMED with sample_idx=0.
- Frame: HDR_BYTE, then NSAMP×{hi,lo}, then ph hi, ph lo, checksum. Default length 68 bytes.
  - hi byte = zero-extended sample[15:8]; lo byte = sample[7:0].
- Checksum: XOR of every byte after the header. It is cleared when SEND_HDR is entered.
- Handshake (AXI-style):
  - tx_data/tx_valid are registered. A byte transfers on a cycle with tx_valid&tx_ready.
  - tx_data must hold stable and tx_valid must stay high until accepted.
  - Next byte is presented the cycle after acceptance; minimum 1 byte/cycle throughput.
  - tx_valid never drops without acceptance.
- sample_in is sampled when the hi byte is loaded, and both bytes come from that one sample.
- dropped_count increments on each trigger_raw_in rising edge while state≠ARMED or enable=0. Saturates at 16'hFFFF.
- enable deasserted mid-frame: the current frame completes. Re-arming is blocked until enable=1.
- trigger_raw_in in the same cycle as the HOLDOFF→ARMED transition is not accepted and is counted as dropped.
- long_trigger_in already low on CAPTURE entry (glitch): wait for a rise, then the fall.
- Async reset mid-frame: all outputs return to reset values immediately and the partial frame is abandoned.

Optional Feature:
- Macro: WAVEFORM_READOUT_TIMESTAMP_EN.
- Defined:
  - A free-running 32-bit cycle counter (reset 0) is latched on trigger_out.
  - Four bytes, MSB first, are sent between the header and the first sample; they are included in the checksum.
  - Frame length becomes 72.
- Undefined: no counter, 68-byte frame.

Decomposition:
- Package waveform_readout_pkg:
  - state enum type.
  - Frame-length constants (with and without timestamp).
  - Default HDR_BYTE.
- Sub-module tx_byte_reg: single-entry valid/ready output register holding tx_data/tx_valid. It takes load/byte_in and reports accept.

Test Plan:
- Trigger in ARMED, sample[i]=i*3, ph=0x0123, tx_ready=1 → 68 bytes: A5, 00 00, 00 03, …, 00 5D, 01 23, XOR checksum; busy then low after 64 holdoff cycles.
- tx_ready toggled with random 30% duty → identical byte stream; tx_data stable whenever tx_valid&!tx_ready.
- 5 trigger pulses during readout and 2 with enable=0 → dropped_count=7; trigger_out stays 0 for all.
- Sample 14'h3FFF → bytes 3F FF; ph 0 → 00 00; checksum matches the model.
- rst_n low at byte 20 → tx_valid=0, state ARMED, dropped_count=0 next cycle; a new trigger yields a full clean frame.
- WAVEFORM_READOUT_TIMESTAMP_EN with trigger at cycle 1000 after reset → bytes 2–5 = 00 00 03 E8; frame length 72.
